joy_serial_responder: RTL and testbench

Joystick-side end of the serial dual-joystick link: captures two 12-bit active-low joystick words and shifts them out on a single data line, clocked and framed by the host's JOY_CLK/JOY_LOAD. It replaces the parallel-in/serial-out shift-register chain on the joystick adapter board. It is used in bench rigs and in a loop-back build where one FPGA feeds another FPGA's joystick reader. JOY_CLK and JOY_LOAD are asynchronous to clk_i and are synchronized internally.

---
 rtl/joy_serial_responder.sv | 115 +++++++++++
 tb/tb_joy_serial_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_responder.sv
// rtl/joy_serial_responder.sv - joystick-side serial responder for the dual-joystick link
module joy_serial_responder #(
   parameter int PAD_BITS   = 1,
   parameter int FRAME_BITS = 24
) (
   input  logic        clk_i,
   input  logic        res_n_i,
   input  logic [11:0] joy1_i,
   input  logic [11:0] joy2_i,
   input  logic        joy_clk_i,
   input  logic        joy_load_i,
   output logic        joy_data_o,
   output logic        frame_o,
   output logic        overrun_o
);

   localparam int SR_W  = PAD_BITS + FRAME_BITS;
   localparam int CNT_W = $clog2(PAD_BITS + FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SR_W);

   typedef enum logic [1:0] {
      LOADING   = 2'd0,
      SHIFTING  = 2'd1,
      EXHAUSTED = 2'd2
   } state_t;

   logic [1:0]       clk_sync_q, clk_sync_d;
   logic [1:0]       load_sync_q, load_sync_d;
   logic             clk_prev_q, clk_prev_d;
   logic             load_prev_q, load_prev_d;
   logic [SR_W-1:0]  sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_q, frame_d;
   logic             overrun_q, overrun_d;
   state_t           state_q, state_d;

   logic             clk_s;
   logic             load_s;
   logic             rise;
   logic [CNT_W-1:0] cnt_inc;
   logic [23:0]      frame_bits;

   assign clk_s   = clk_sync_q[1];
   assign load_s  = load_sync_q[1];
   assign rise    = clk_s & ~clk_prev_q;
   assign cnt_inc = cnt_q + 1'b1;

   // First transmitted bit sits in the MSB.
   assign frame_bits = {joy1_i[8], joy1_i[6], joy1_i[5], joy1_i[4],
                        joy1_i[3], joy1_i[2], joy1_i[1], joy1_i[0],
                        joy2_i[8], joy2_i[6], joy2_i[5], joy2_i[4],
                        joy2_i[3], joy2_i[2], joy2_i[1], joy2_i[0],
                        joy2_i[10], joy2_i[11], joy2_i[9], joy2_i[7],
                        joy1_i[10], joy1_i[11], joy1_i[9], joy1_i[7]};

   always_comb begin
      clk_sync_d  = {clk_sync_q[0], joy_clk_i};
      load_sync_d = {load_sync_q[0], joy_load_i};
      clk_prev_d  = clk_s;
      load_prev_d = load_s;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      frame_d     = 1'b0;
      overrun_d   = overrun_q;
      state_d     = state_q;

      if (!load_s) begin
         // Reload every cycle while load is low so the last sample wins.
         sr_d      = {{PAD_BITS{1'b1}}, frame_bits};
         cnt_d     = '0;
         overrun_d = 1'b0;
         frame_d   = load_prev_q;
         state_d   = LOADING;
      end else if (rise) begin
         if (state_q == EXHAUSTED) begin
            overrun_d = 1'b1;
         end else begin
            sr_d    = {sr_q[SR_W-2:0], 1'b1};
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CNT_MAX) ? EXHAUSTED : SHIFTING;
         end
      end else if (state_q == LOADING) begin
         state_d = SHIFTING;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!res_n_i) begin
         clk_sync_q  <= 2'b11;
         load_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         load_prev_q <= 1'b1;
         sr_q        <= '1;
         cnt_q       <= '0;
         frame_q     <= 1'b0;
         overrun_q   <= 1'b0;
         state_q     <= SHIFTING;
      end else begin
         clk_sync_q  <= clk_sync_d;
         load_sync_q <= load_sync_d;
         clk_prev_q  <= clk_prev_d;
         load_prev_q <= load_prev_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         overrun_q   <= overrun_d;
         state_q     <= state_d;
      end
   end

   assign joy_data_o = sr_q[SR_W-1];
   assign frame_o    = frame_q;
   assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_joy_serial_responder.sv
// tb/tb_joy_serial_responder.sv - scoreboard bench for joy_serial_responder
module tb_joy_serial_responder;

   localparam int PAD = 1;

   logic        clk = 1'b0;
   logic        res_n;
   logic [11:0] joy1;
   logic [11:0] joy2;
   logic        joy_clk;
   logic        joy_load;
   logic        joy_data_o;
   logic        frame_o;
   logic        overrun_o;

   int checks    = 0;
   int failures  = 0;
   int frame_cnt = 0;
   logic exp_q[$];

   joy_serial_responder #(.PAD_BITS(PAD), .FRAME_BITS(24)) dut (
      .clk_i      (clk),
      .res_n_i    (res_n),
      .joy1_i     (joy1),
      .joy2_i     (joy2),
      .joy_clk_i  (joy_clk),
      .joy_load_i (joy_load),
      .joy_data_o (joy_data_o),
      .frame_o    (frame_o),
      .overrun_o  (overrun_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (res_n === 1'b1 && frame_o === 1'b1) frame_cnt <= frame_cnt + 1;

   function automatic logic model_bit(input logic [11:0] j1, input logic [11:0] j2, input int idx);
      int unsigned sel_tbl [24] = '{8, 6, 5, 4, 3, 2, 1, 0, 8, 6, 5, 4, 3, 2, 1, 0,
                                    10, 11, 9, 7, 10, 11, 9, 7};
      logic [11:0] w;
      w = (idx < 8 || idx >= 20) ? j1 : j2;
      return w[sel_tbl[idx]];
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [11:0] j1, input logic [11:0] j2);
      exp_q.delete();
      for (int i = 0; i < PAD; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < 24; i++) exp_q.push_back(model_bit(j1, j2, i));
   endtask

   task automatic pulse_rise();
      joy_clk = 1'b1;
      wait_cycles(5);
      joy_clk = 1'b0;
      wait_cycles(5);
   endtask

   task automatic load_frame(input logic [11:0] j1, input logic [11:0] j2);
      joy1 = j1;
      joy2 = j2;
      joy_load = 1'b0;
      wait_cycles(4);
      joy_load = 1'b1;
      wait_cycles(4);
   endtask

   task automatic run_frame(input int n_rises, input string tag);
      logic exp;
      for (int k = 0; k <= n_rises; k++) begin
         if (k > 0) pulse_rise();
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
         checks++;
         if (joy_data_o !== exp) begin
            failures++;
            $display("FAIL %s bit %0d: joy_data_o=%b expected %b", tag, k, joy_data_o, exp);
         end
      end
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      joy_clk = 1'b0;
      joy_load = 1'b1;
      joy1 = 12'hFFF;
      joy2 = 12'hFFF;
      wait_cycles(4);
      checks++;
      if (joy_data_o !== 1'b1 || frame_o !== 1'b0 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: data=%b frame=%b overrun=%b expected 1 0 0", joy_data_o, frame_o, overrun_o);
      end
      res_n = 1'b1;
      exp_q.delete();
      run_frame(10, "reset_idle");
      checks++;
      if (overrun_o !== 1'b0 || frame_cnt !== 0) begin
         failures++;
         $display("FAIL reset_idle_flags: overrun=%b frames=%0d expected 0 0", overrun_o, frame_cnt);
      end
   endtask

   task automatic test_basic();
      int f0 = frame_cnt;
      load_frame(12'hFFE, 12'hFFF);
      push_frame(12'hFFE, 12'hFFF);
      run_frame(25, "basic_p1");
      checks++;
      if (frame_cnt - f0 !== 1) begin
         failures++;
         $display("FAIL basic_frame_pulse: pulses=%0d expected 1", frame_cnt - f0);
      end
      checks++;
      if (overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL basic_overrun: overrun=%b expected 0", overrun_o);
      end
   endtask

   task automatic test_player2();
      load_frame(12'hFFF, 12'h3FF);
      push_frame(12'hFFF, 12'h3FF);
      run_frame(25, "full_p2");
   endtask

   task automatic test_overrun();
      pulse_rise();
      pulse_rise();
      checks++;
      if (overrun_o !== 1'b1 || joy_data_o !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set: overrun=%b data=%b expected 1 1", overrun_o, joy_data_o);
      end
      joy_load = 1'b0;
      wait_cycles(2);
      checks++;
      if (overrun_o !== 1'b1) begin
         failures++;
         $display("FAIL overrun_hold: overrun=%b expected 1", overrun_o);
      end
      wait_cycles(1);
      checks++;
      if (overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear: overrun=%b expected 0", overrun_o);
      end
      joy_load = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_load_priority();
      int f0 = frame_cnt;
      joy1 = 12'hEFE;
      joy2 = 12'hFFF;
      joy_load = 1'b0;
      wait_cycles(3);
      for (int i = 0; i < 2; i++) begin
         joy_clk = 1'b1;
         wait_cycles(4);
         joy_clk = 1'b0;
         wait_cycles(4);
      end
      joy1 = 12'hFFE;
      wait_cycles(6);
      joy_load = 1'b1;
      wait_cycles(4);
      joy1 = 12'h000;
      joy2 = 12'h000;
      push_frame(12'hFFE, 12'hFFF);
      run_frame(25, "load_prio");
      checks++;
      if (frame_cnt - f0 !== 1) begin
         failures++;
         $display("FAIL prio_frame_pulse: pulses=%0d expected 1", frame_cnt - f0);
      end
   endtask

   task automatic test_reset_mid();
      load_frame(12'hA5A, 12'h5A5);
      push_frame(12'hA5A, 12'h5A5);
      run_frame(10, "pre_reset");
      res_n = 1'b0;
      wait_cycles(1);
      checks++;
      if (joy_data_o !== 1'b1 || overrun_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: data=%b overrun=%b expected 1 0", joy_data_o, overrun_o);
      end
      res_n = 1'b1;
      wait_cycles(2);
      load_frame(12'h3C3, 12'hC3C);
      push_frame(12'h3C3, 12'hC3C);
      run_frame(25, "post_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_player2();
      test_overrun();
      test_load_priority();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
